// File: rtl/ifetch_queue.sv
// Instruction fetch: issues in-order word requests from fetch_pc and queues {pc, data} for decode.
// Optional IFETCH_BYPASS_EN forwards a response to inst_* in the same cycle when the queue is empty.
module ifetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [31:0]   pc_mem   [DEPTH];
   logic [31:0]   data_mem [DEPTH];
   logic [PW-1:0] alloc_ptr, fill_ptr, rd_ptr, drop_cnt;
   logic [31:0]   fetch_pc;
   logic [PW-1:0] allocated, unfilled;
   logic          req_fire, rsp_keep, pop, queue_nonempty;

   assign allocated      = alloc_ptr - rd_ptr;
   assign unfilled       = alloc_ptr - fill_ptr;
   assign queue_nonempty = (fill_ptr != rd_ptr);

   assign imem_req_valid = !rst && !redirect_valid && (drop_cnt == '0) && (allocated < PW'(DEPTH));
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;
   // Responses belonging to a flushed stream are never written.
   assign rsp_keep       = imem_rsp_valid && !redirect_valid && (drop_cnt == '0);

`ifdef IFETCH_BYPASS_EN
   logic bypass;
   assign bypass     = rsp_keep && !queue_nonempty;
   assign inst_valid = queue_nonempty || bypass;
   assign inst_data  = bypass ? imem_rsp_data : data_mem[rd_ptr[AW-1:0]];
`else
   assign inst_valid = queue_nonempty;
   assign inst_data  = data_mem[rd_ptr[AW-1:0]];
`endif
   // Under bypass fill_ptr == rd_ptr, so the read slot already holds the right pc.
   assign inst_pc    = pc_mem[rd_ptr[AW-1:0]];
   assign pop        = inst_valid && inst_ready && !redirect_valid;

   always_ff @(posedge clk) begin
      if (req_fire)
         pc_mem[alloc_ptr[AW-1:0]] <= fetch_pc;
      if (rsp_keep)
         data_mem[fill_ptr[AW-1:0]] <= imem_rsp_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc  <= RESET_PC;
         alloc_ptr <= '0;
         fill_ptr  <= '0;
         rd_ptr    <= '0;
         drop_cnt  <= '0;
      end else if (redirect_valid) begin
         fetch_pc  <= {redirect_pc[31:2], 2'b00};
         alloc_ptr <= '0;
         fill_ptr  <= '0;
         rd_ptr    <= '0;
         // Every unfilled slot still owes a response; one arriving now is already gone.
         drop_cnt  <= drop_cnt + unfilled - {{(PW-1){1'b0}}, imem_rsp_valid};
      end else begin
         if (req_fire) begin
            alloc_ptr <= alloc_ptr + 1'b1;
            fetch_pc  <= fetch_pc + 32'd4;
         end
         if (rsp_keep)
            fill_ptr <= fill_ptr + 1'b1;
         if (imem_rsp_valid && (drop_cnt != '0))
            drop_cnt <= drop_cnt - 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end
endmodule

// File: tb/tb_ifetch_queue.sv
// Random-stimulus bench for ifetch_queue with an in-order memory model and an epoch-based reference.
module tb_ifetch_queue;
   localparam int          DEPTH = 4;
   localparam logic [31:0] RPC   = 32'h0000_0100;

   logic        clk = 1'b0, rst = 1'b1;
   logic        redirect_valid = 1'b0, imem_req_ready = 1'b0, imem_rsp_valid = 1'b0, inst_ready = 1'b0;
   logic [31:0] redirect_pc = '0, imem_rsp_data = '0;
   logic        imem_req_valid, inst_valid;
   logic [31:0] imem_req_addr, inst_data, inst_pc;

   ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
      .clk(clk), .rst(rst),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          epoch;
   } pend_t;

   pend_t       pend[$];   // requests the memory still owes a response for
   logic [31:0] exp_q[$];  // PCs decode should see, in order
   int          n_cmp = 0, n_fail = 0, total_pops = 0;
   int          cur_epoch = 0, alloc_n = 0, kept_n = 0, pop_n = 0;
   logic [31:0] model_pc = RPC;

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5a5a_1234;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: fetch address, occupancy and stale-response bookkeeping.
   always @(negedge clk) begin : model
      int   stale;
      logic exp_rv, exp_iv;
      if (rst) begin
         check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
         check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
         pend.delete();
         exp_q.delete();
         model_pc = RPC;
         alloc_n = 0; kept_n = 0; pop_n = 0;
         cur_epoch++;
      end else begin
         stale = 0;
         foreach (pend[i]) if (pend[i].epoch != cur_epoch) stale++;
         exp_rv = !redirect_valid && (stale == 0) && ((alloc_n - pop_n) < DEPTH);
         check("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_rv});
         if (imem_req_valid)
            check("req_addr", imem_req_addr, model_pc);
         exp_iv = (kept_n - pop_n) > 0;
`ifdef IFETCH_BYPASS_EN
         if (imem_rsp_valid && !redirect_valid && pend.size() > 0 &&
             pend[0].epoch == cur_epoch && kept_n == pop_n)
            exp_iv = 1'b1;
`endif
         check("inst_valid", {31'd0, inst_valid}, {31'd0, exp_iv});

         if (imem_req_valid && imem_req_ready) begin
            pend.push_back('{imem_req_addr, cur_epoch});
            exp_q.push_back(model_pc);
            model_pc = model_pc + 32'd4;
            alloc_n++;
         end
         if (imem_rsp_valid && pend.size() > 0) begin
            if (pend[0].epoch == cur_epoch && !redirect_valid) kept_n++;
            void'(pend.pop_front());
         end
         if (inst_valid && inst_ready && !redirect_valid) pop_n++;
         if (redirect_valid) begin
            cur_epoch++;
            model_pc = {redirect_pc[31:2], 2'b00};
            alloc_n = 0; kept_n = 0; pop_n = 0;
            exp_q.delete();
         end
      end
   end

   // Scoreboard monitor: every accepted instruction must match the next expected PC and its word.
   always @(negedge clk) begin : monitor
      logic [31:0] e;
      if (!rst && inst_valid && inst_ready && !redirect_valid) begin
         total_pops++;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL pop_underflow: got inst_pc %h expected no instruction", inst_pc);
         end else begin
            e = exp_q.pop_front();
            check("inst_pc", inst_pc, e);
            check("inst_data", inst_data, memfn(e));
         end
      end
   end

   initial begin : driver
      logic [31:0] targets [4];
      int          phase;
      targets[0] = 32'h0000_2003;
      targets[1] = 32'hFFFF_FFF8;
      targets[2] = 32'h0000_0040;
      targets[3] = 32'h1234_5677;

      repeat (3) @(posedge clk);
      #3 rst = 1'b0;

      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(posedge clk);
         #1;
         phase = (cyc / 250) % 4;
         imem_req_ready = (phase == 0) ? 1'b1 : ($urandom_range(0, 99) < 75);
         case (phase)
            0:       inst_ready = 1'b1;
            1:       inst_ready = ($urandom_range(0, 99) < 50);
            2:       inst_ready = ((cyc % 250) > 180);
            default: inst_ready = ($urandom_range(0, 99) < 80);
         endcase
         redirect_valid = (phase != 0) && ($urandom_range(0, 99) < 4);
         redirect_pc    = targets[$urandom_range(0, 3)] ^ {30'd0, 2'($urandom_range(0, 3))};
         if (pend.size() > 0 && (phase == 0 || $urandom_range(0, 99) < 70)) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memfn(pend[0].addr);
         end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
         end

         if (cyc == 2100) begin
            #2 rst = 1'b1;
            #1;
            check("async_rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
            check("async_rst_inst_valid", {31'd0, inst_valid}, 32'd0);
            redirect_valid = 1'b0;
            imem_rsp_valid = 1'b0;
            @(posedge clk);
            #3 rst = 1'b0;
         end
      end

      redirect_valid = 1'b0;
      imem_rsp_valid = 1'b0;
      repeat (2) @(posedge clk);
      check("progress", {31'd0, (total_pops > 200)}, 32'd1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction-fetch stage that sits directly downstream of the PC register.
- Owns the running fetch address and issues in-order word requests to instruction memory.
- Buffers returned instructions, each tagged with its PC, in a DEPTH-entry queue and hands them to decode over a valid/ready handshake.
- A redirect from execute (branch or jump target) reloads the fetch address, flushes the queue and discards in-flight responses.

Parameters:
- DEPTH, 4: queue entries; power of 2, ≥2; also the maximum number of outstanding requests.
- RESET_PC, 32'h0000_0000: fetch address after reset.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (treated as 00)
- imem_req_valid  out  1  request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  word address of request
- imem_rsp_valid  in  1  response valid; in request order, ≥1 cycle after acceptance
- imem_rsp_data  in  32  instruction word
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode accepts
- inst_data  out  32  instruction
- inst_pc  out  32  PC of inst_data

Behaviour:
- Storage: DEPTH entries of {pc, data}. Three pointers, each log2(DEPTH)+1 bits, wrap-around via the extra MSB:
  - alloc_ptr: advances on request handshake; writes pc.
  - fill_ptr: advances on a kept response; writes data.
  - rd_ptr: advances on pop.
- Allocated = alloc_ptr − rd_ptr, ≤ DEPTH. Unfilled = alloc_ptr − fill_ptr.
- Counters: fetch_pc (32b) and drop_cnt (log2(DEPTH)+1 bits).
- Reset: fetch_pc = RESET_PC; all pointers = 0; drop_cnt = 0; imem_req_valid = 0, inst_valid = 0 during reset. Data outputs are don't-care while their valid is low.
- imem_req_valid = !redirect_valid && drop_cnt == 0 && allocated < DEPTH.
- imem_req_addr = fetch_pc.
- Request handshake (valid & ready): entry[alloc].pc = fetch_pc; alloc_ptr++; fetch_pc += 4. fetch_pc wraps mod 2^32 (32'hFFFF_FFFC → 0).
- Response, drop_cnt > 0: discarded; drop_cnt−−.
- Response, drop_cnt == 0: entry[fill].data = imem_rsp_data; fill_ptr++. Latency: response cycle N → inst_valid in cycle N+1.
- inst_valid = (fill_ptr != rd_ptr); inst_data and inst_pc are taken from entry[rd]. Pop on inst_valid & inst_ready.
- Redirect cycle (highest priority):
  - No request is issued and the pop is ignored.
  - Next state: rd_ptr = alloc_ptr = fill_ptr = 0; fetch_pc = {redirect_pc[31:2], 2'b00}.
  - drop_cnt_next = drop_cnt + unfilled − (imem_rsp_valid ? 1 : 0). A response in the redirect cycle belongs to the old stream and counts as dropped.
  - Requests stay blocked until drop_cnt == 0, which bounds drop_cnt ≤ DEPTH.
- Simultaneous fill and pop in the same cycle: both take effect.
- Full (allocated == DEPTH): no request is issued; a pop that cycle does not enable a same-cycle request.
- Back-to-back redirects: each reloads fetch_pc; drop_cnt accumulates as above.
- Response with nothing outstanding: protocol violation, behaviour undefined.

Optional Feature:
- Macro: IFETCH_BYPASS_EN.
- Defined: when fill_ptr == rd_ptr and a kept response arrives, inst_valid = 1 in the same cycle, inst_data = imem_rsp_data and inst_pc = entry[fill].pc.
  - If inst_ready is also high, fill_ptr and rd_ptr both advance.
  - Otherwise the data is written to the queue as normal.
  - Bypass is suppressed in a redirect cycle and while drop_cnt > 0.
- Undefined: no combinational path from imem_rsp to inst_*; latency is fixed at 1 cycle.

Test Plan:
- Reset with RESET_PC = 32'h100, imem_req_ready = 1, 1-cycle memory, inst_ready = 1 → imem_req_addr = 0x100, 0x104, 0x108…; inst_pc follows the same sequence, one instruction per cycle after fill.
- inst_ready = 0, DEPTH = 4 → exactly 4 requests (0x0–0xC), then imem_req_valid = 0; raise inst_ready → pops resume in order and requests restart at 0x10.
- 3 requests outstanding, redirect_pc = 0x2003 asserted together with one response → drop_cnt = 2, next 2 responses discarded, then first request addr = 0x2000, first inst_pc = 0x2000.
- Mid-operation asynchronous rst pulse between clock edges → inst_valid and imem_req_valid fall immediately; after release, fetch restarts at RESET_PC.
- fetch_pc = 0xFFFF_FFFC, one request accepted → next imem_req_addr = 0x0000_0000.
- Bypass (IFETCH_BYPASS_EN defined), queue empty: response 0xDEADBEEF with inst_ready = 1 → inst_valid and inst_data = 0xDEADBEEF in the same cycle. Without the macro → the same word appears one cycle later.
